// File: rtl/heart_model.sv
// heart_model: closed-loop cardiac model driving sa/sv senses from pa/pv paces
module heart_model #(
    parameter int CNT_W       = 16,
    parameter int SA_INTERVAL = 800,
    parameter int AV_DELAY    = 150,
    parameter int VE_INTERVAL = 1500,
    parameter int PULSE_W     = 20,
    parameter int A_REFRACT   = 40,
    parameter int V_REFRACT   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       av_block,
    input  logic       pa,
    input  logic       pv,
    output logic       sa,
    output logic       sv,
    output logic [7:0] a_beats,
    output logic [7:0] v_beats
);
    typedef enum logic {A_WAIT, A_REFR} a_st_t;
    typedef enum logic {V_WAIT, V_REFR} v_st_t;

    localparam logic [CNT_W-1:0] MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SA_T  = CNT_W'(SA_INTERVAL - 1);
    localparam logic [CNT_W-1:0] AV_T  = CNT_W'(AV_DELAY - 1);
    localparam logic [CNT_W-1:0] VE_T  = CNT_W'(VE_INTERVAL - 1);
    localparam logic [CNT_W-1:0] PW_T  = CNT_W'(PULSE_W - 1);

    a_st_t            a_st, a_nx;
    v_st_t            v_st, v_nx;
    logic [CNT_W-1:0] a_cnt, v_cnt, av_cnt, sa_p, sv_p;
    logic             pend;
    logic             a_int, a_pace, a_dep, av_exp, v_pace, v_int, v_dep, arm;

    // state registers; en=0 holds both chambers idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_st <= A_WAIT;
            v_st <= V_WAIT;
        end else if (!en) begin
            a_st <= A_WAIT;
            v_st <= V_WAIT;
        end else begin
            a_st <= a_nx;
            v_st <= v_nx;
        end
    end

    // refractory is entered on depolarization and left once the count reaches the period
    always_comb begin
        a_nx = a_dep ? A_REFR
             : (a_st == A_REFR && 32'(a_cnt) + 32'd1 >= 32'(A_REFRACT)) ? A_WAIT : a_st;
        v_nx = v_dep ? V_REFR
             : (v_st == V_REFR && 32'(v_cnt) + 32'd1 >= 32'(V_REFRACT)) ? V_WAIT : v_st;
    end

    // beat decode: intrinsic beats win over atrial pace, pv wins over conduction and escape
    always_comb begin
        a_int  = a_st == A_WAIT && a_cnt == SA_T;
        a_pace = a_st == A_WAIT && pa && !a_int;
        a_dep  = a_int || a_pace;
        arm    = a_dep && !av_block;
        av_exp = pend && av_cnt == AV_T;
        v_pace = v_st == V_WAIT && pv;
        v_int  = !v_pace && ((av_exp && v_st == V_WAIT) || (v_st == V_WAIT && v_cnt == VE_T));
        v_dep  = v_pace || v_int;
    end

    // interval counters, AV pending flag, sense pulses and beat counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt   <= '0;
            v_cnt   <= '0;
            av_cnt  <= '0;
            sa_p    <= '0;
            sv_p    <= '0;
            pend    <= 1'b0;
            sa      <= 1'b0;
            sv      <= 1'b0;
            a_beats <= '0;
            v_beats <= '0;
        end else if (!en) begin
            a_cnt   <= '0;
            v_cnt   <= '0;
            av_cnt  <= '0;
            sa_p    <= '0;
            sv_p    <= '0;
            pend    <= 1'b0;
            sa      <= 1'b0;
            sv      <= 1'b0;
            a_beats <= '0;
            v_beats <= '0;
        end else begin
            a_cnt   <= a_dep ? '0 : (a_cnt == MAX ? a_cnt : a_cnt + 1'b1);
            v_cnt   <= v_dep ? '0 : (v_cnt == MAX ? v_cnt : v_cnt + 1'b1);
            av_cnt  <= arm ? '0 : (pend && av_cnt != MAX) ? av_cnt + 1'b1 : av_cnt;
            pend    <= arm ? 1'b1 : (av_block || v_dep || av_exp) ? 1'b0 : pend;
            sa      <= a_int ? 1'b1 : (sa && sa_p == PW_T) ? 1'b0 : sa;
            sa_p    <= a_int ? '0 : sa ? sa_p + 1'b1 : sa_p;
            sv      <= v_int ? 1'b1 : (sv && sv_p == PW_T) ? 1'b0 : sv;
            sv_p    <= v_int ? '0 : sv ? sv_p + 1'b1 : sv_p;
            a_beats <= a_beats + 8'(a_dep);
            v_beats <= v_beats + 8'(v_dep);
        end
    end
endmodule

// File: tb/tb_heart_model.sv
// tb_heart_model: directed checks of heart_model with shortened intervals
module tb_heart_model;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       av_block = 1'b0;
    logic       pa = 1'b0;
    logic       pv = 1'b0;
    logic       sa, sv;
    logic [7:0] a_beats, v_beats;
    int         total = 0;
    int         bad = 0;
    int         e = 0;

    heart_model #(
        .CNT_W(16), .SA_INTERVAL(100), .AV_DELAY(30), .VE_INTERVAL(200),
        .PULSE_W(20), .A_REFRACT(40), .V_REFRACT(60)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .av_block(av_block), .pa(pa), .pv(pv),
        .sa(sa), .sv(sv), .a_beats(a_beats), .v_beats(v_beats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic run_to(input int k);
        while (e < k) tick();
    endtask

    task automatic restart(input logic blk);
        rst = 1'b1;
        en = 1'b0;
        pa = 1'b0;
        pv = 1'b0;
        av_block = blk;
        repeat (2) tick();
        rst = 1'b0;
        en = 1'b1;
        e = 0;
    endtask

    initial begin
        // 1: free-running sinus rhythm with conduction
        restart(1'b0);
        chk("rst_sa", sa, 0);
        chk("rst_abeats", a_beats, 0);
        chk("rst_vbeats", v_beats, 0);
        run_to(99);  chk("t1_sa99", sa, 0);
        run_to(100); chk("t1_sa100", sa, 1);
        run_to(119); chk("t1_sa119", sa, 1);
        run_to(120); chk("t1_sa120", sa, 0);
        run_to(129); chk("t1_sv129", sv, 0);
        run_to(130); chk("t1_sv130", sv, 1);
        run_to(149); chk("t1_sv149", sv, 1);
        run_to(150); chk("t1_sv150", sv, 0);
        run_to(200); chk("t1_sa200", sa, 1);
        run_to(230); chk("t1_sv230", sv, 1);
        run_to(330);
        chk("t1_abeats", a_beats, 3);
        chk("t1_vbeats", v_beats, 3);

        // 2: complete block, ventricle escapes every 200
        restart(1'b1);
        run_to(130); chk("t2_sv130", sv, 0);
        run_to(199); chk("t2_sv199", sv, 0);
        run_to(200); chk("t2_sv200", sv, 1);
        chk("t2_sa200", sa, 1);
        run_to(400);
        chk("t2_sv400", sv, 1);
        chk("t2_abeats", a_beats, 4);
        chk("t2_vbeats", v_beats, 2);
        en = 1'b0;
        tick();
        chk("en0_sa", sa, 0);
        chk("en0_abeats", a_beats, 0);
        chk("en0_vbeats", v_beats, 0);

        // 3: atrial pace at a_cnt=50
        restart(1'b0);
        run_to(50); pa = 1'b1; tick(); pa = 1'b0;
        chk("t3_sa51", sa, 0);
        chk("t3_abeats51", a_beats, 1);
        run_to(81);  chk("t3_sv81", sv, 1);
        run_to(100); chk("t3_sa100", sa, 0);
        run_to(150); chk("t3_sa150", sa, 0);
        run_to(151); chk("t3_sa151", sa, 1);
        chk("t3_abeats151", a_beats, 2);

        // 4: paces in refractory periods are ignored
        restart(1'b0);
        run_to(110); pa = 1'b1; tick(); pa = 1'b0;
        chk("t4_abeats", a_beats, 1);
        run_to(149); pv = 1'b1; tick(); pv = 1'b0;
        chk("t4_vbeats", v_beats, 1);
        run_to(199); chk("t4_sa199", sa, 0);
        run_to(200); chk("t4_sa200", sa, 1);
        chk("t4_abeats200", a_beats, 2);

        // 5: fusion of pv with conduction expiry
        restart(1'b0);
        run_to(129); pv = 1'b1; tick(); pv = 1'b0;
        chk("t5_sv130", sv, 0);
        chk("t5_vbeats130", v_beats, 1);
        av_block = 1'b1;
        run_to(329); chk("t5_sv329", sv, 0);
        chk("t5_vbeats329", v_beats, 1);
        run_to(330); chk("t5_sv330", sv, 1);
        chk("t5_vbeats330", v_beats, 2);

        // 6: asynchronous reset mid sense pulse
        restart(1'b0);
        run_to(104); chk("t6_sa104", sa, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_sa_rst", sa, 0);
        chk("t6_abeats_rst", a_beats, 0);
        chk("t6_vbeats_rst", v_beats, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        e = 0;
        run_to(99);  chk("t6_sa99", sa, 0);
        run_to(100); chk("t6_sa100", sa, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/heart_model.md
Name: heart_model

Overview:
- Synthesizable closed-loop cardiac model: the other end of the pacemaker's sense/pace interface.
- Consumes the pacemaker's pace outputs (pa, pv) and produces the sense inputs it monitors (sa, sv).
- Models three things:
  - an intrinsic atrial rhythm;
  - AV conduction, with an optional conduction block;
  - a ventricular escape rhythm and atrial/ventricular refractory periods.
- Used in pacemaker benches and on-board demos in place of hand-written sa/sv stimulus.

Parameters:
- CNT_W, 16, width of all interval counters.
- SA_INTERVAL, 800, cycles between intrinsic atrial depolarizations.
- AV_DELAY, 150, cycles from any atrial depolarization to the conducted ventricular depolarization.
- VE_INTERVAL, 1500, ventricular escape interval, counted from the last ventricular depolarization.
- PULSE_W, 20, width in cycles of each sa/sv sense pulse.
- A_REFRACT, 40, atrial refractory period in cycles, counted from atrial depolarization.
- V_REFRACT, 250, ventricular refractory period in cycles, counted from ventricular depolarization.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  1 = heart running; 0 = hold idle
- av_block  in  1  1 = AV conduction blocked (complete heart block)
- pa  in  1  atrial pace from pacemaker, level-sampled each clk
- pv  in  1  ventricular pace from pacemaker, level-sampled each clk
- sa  out  1  atrial sense pulse, intrinsic beats only
- sv  out  1  ventricular sense pulse, intrinsic beats only
- a_beats  out  8  atrial depolarization count, wraps 255->0
- v_beats  out  8  ventricular depolarization count, wraps 255->0

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst is asynchronous active-high.
  - Reset values: sa=0, sv=0, a_beats=0, v_beats=0; all counters 0; av pending cleared; atrial FSM A_WAIT; ventricular FSM V_WAIT.
  - Reset mid-pulse drops sa/sv immediately.
- en=0:
  - Same clearing as reset, applied synchronously.
  - First counting edge is the first edge with en=1.
- Atrial FSM (A_WAIT, A_REFR):
  - a_cnt counts 0 up each cycle.
  - A_REFR while a_cnt < A_REFRACT; pa is ignored in A_REFR.
  - Intrinsic beat: in A_WAIT, at the edge where a_cnt == SA_INTERVAL-1.
    - a_cnt <= 0.
    - sa <= 1 for exactly PULSE_W cycles.
    - a_beats += 1.
  - Paced beat: pa=1 sampled in A_WAIT.
    - a_cnt <= 0, a_beats += 1, sa stays 0.
  - pa and intrinsic timeout on the same edge: intrinsic wins, sa asserted, single count.
- AV conduction:
  - Every atrial depolarization arms av_cnt=0 with pending=1, unless av_block=1.
  - A new atrial beat re-arms av_cnt (restarts it).
  - Expiry when av_cnt == AV_DELAY-1 while pending.
    - If the ventricle is not refractory: intrinsic ventricular beat.
    - Otherwise the pending event is dropped.
  - Any ventricular depolarization clears pending.
  - av_block rising clears pending.
- Ventricular FSM (V_WAIT, V_REFR):
  - v_cnt counts from the last ventricular depolarization.
  - V_REFR while v_cnt < V_REFRACT; pv is ignored in V_REFR.
  - Depolarization sources, priority pv > conduction expiry > escape (v_cnt == VE_INTERVAL-1).
  - On depolarization: v_cnt <= 0, v_beats += 1.
  - sv = 1 for PULSE_W cycles only for conduction or escape beats; sv stays 0 for paced beats.
  - Fusion (pv and conduction expiry on the same edge) is treated as paced: no sv, one count.
- Sense pulse retrigger: a new intrinsic beat during an active sa/sv pulse restarts that pulse width counter. Unreachable when refractory >= PULSE_W; still defined.
- Timing and widths:
  - Output latency 0: sa/sv/count updates occur on the same edge as the triggering event (all outputs registered).
  - Counters saturate at 2^CNT_W-1; parameters must be < 2^CNT_W.

Test Plan:
Benches override parameters: SA_INTERVAL=100, AV_DELAY=30, VE_INTERVAL=200, PULSE_W=20, A_REFRACT=40, V_REFRACT=60.
1. rst 1->0, en=1, pa=pv=0 -> sa high edges 100..119, sv high 130..149; pattern repeats every 100; a_beats=v_beats=3 after 330 edges.
2. av_block=1, no pacing -> sa every 100; sv every 200 (escape), first at edge 200; v_beats=a_beats/2.
3. pa 1-cycle pulse at a_cnt=50 -> no sa; next sa 100 cycles after pa; sv 30 cycles after pa; a_beats +1.
4. pa at a_cnt=10 (refractory) -> ignored; sa at normal edge 100; pv 20 cycles after a ventricular beat -> ignored, v_beats unchanged.
5. pv on the same edge as conduction expiry -> sv stays 0, v_beats +1 exactly once; next escape measured from that edge.
6. rst asserted at cycle 5 of an sa pulse -> sa=0 immediately; a_beats=v_beats=0; after release, first sa 100 edges later.
